// File: rtl/serial_fas.sv
// rtl/serial_fas.sv - bit-serial N-bit adder/subtractor around one full adder/subtractor cell
// Optional signed-overflow logic is built only when SERIAL_FAS_OVF_EN is defined.
module serial_fas #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         a_ns,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         ovf
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_q;
  logic [N-1:0]   a_q, b_q, acc_q, acc_d, s_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           a_ns_q, carry_q, busy_q, done_q, cout_q;
  logic           b_eff, sum, carry_d, last;
`ifdef SERIAL_FAS_OVF_EN
  logic           cmsb_q;
`endif

  // One fas step on the current bit; b is inverted for subtract, carry-in supplies the +1.
  always_comb begin
    b_eff   = b_q[cnt_q] ^ ~a_ns_q;
    sum     = a_q[cnt_q] ^ b_eff ^ carry_q;
    carry_d = (a_q[cnt_q] & b_eff) | (carry_q & (a_q[cnt_q] ^ b_eff));
    last    = (cnt_q == CW'(N - 1));
    cnt_d   = cnt_q + 1'b1;
    acc_d   = acc_q;
    acc_d[cnt_q] = sum;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      a_ns_q  <= 1'b0;
      acc_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_FAS_OVF_EN
      cmsb_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            a_ns_q  <= a_ns;
            carry_q <= ~a_ns;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q   <= acc_d;
          carry_q <= carry_d;
          cnt_q   <= cnt_d;
          if (last) begin
            s_q     <= acc_d;
            cout_q  <= carry_d;
`ifdef SERIAL_FAS_OVF_EN
            cmsb_q  <= carry_q;
`endif
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign cout = cout_q;
`ifdef SERIAL_FAS_OVF_EN
  // Signed overflow: carry into MSB differs from carry out of MSB.
  assign ovf  = cmsb_q ^ cout_q;
`else
  assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_fas.sv
// tb/tb_serial_fas.sv - directed self-checking bench for serial_fas (N=8)
// Expected ovf for the 0x7F+0x01 case follows SERIAL_FAS_OVF_EN.
module tb_serial_fas;

  localparam int N = 8;
`ifdef SERIAL_FAS_OVF_EN
  localparam logic EXP_OVF_7F = 1'b1;
`else
  localparam logic EXP_OVF_7F = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [N-1:0] a, b;
  logic         a_ns;
  logic         busy, done, cout, ovf;
  logic [N-1:0] s;

  int cmp_cnt = 0;
  int err_cnt = 0;

  serial_fas #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .a_ns(a_ns),
    .busy(busy), .done(done), .s(s), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and wait (bounded) for done; leaves the bench in the done cycle.
  task automatic do_op(input logic [N-1:0] av, input logic [N-1:0] bv, input logic ns,
                       output int busy_cycles, output bit got_done, output bit overlap);
    a = av; b = bv; a_ns = ns; start = 1'b1;
    step();
    start = 1'b0; a = 8'hEE; b = 8'h77; a_ns = ~ns;
    busy_cycles = 0; got_done = 1'b0; overlap = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy && done) overlap = 1'b1;
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (busy) busy_cycles++;
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; a = 8'h55; b = 8'h33; a_ns = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      cmp_cnt++;
      if ({busy, done, s, cout, ovf} !== 12'h000) begin
        err_cnt++;
        $display("FAIL reset_outputs cyc%0d: got busy=%b done=%b s=%h cout=%b ovf=%b, want all 0",
                 i, busy, done, s, cout, ovf);
      end
    end
    start = 1'b0; rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      cmp_cnt++;
      if ({busy, done} !== 2'b00) begin
        err_cnt++;
        $display("FAIL reset_release_idle cyc%0d: got busy=%b done=%b, want 0 0", i, busy, done);
      end
    end
  endtask

  task automatic test_arith(input string name, input logic [N-1:0] av, input logic [N-1:0] bv,
                            input logic ns, input logic [N-1:0] es, input logic ec, input logic eo);
    int bc; bit gd, ov;
    do_op(av, bv, ns, bc, gd, ov);
    cmp_cnt++;
    if (!gd || bc != N || ov) begin
      err_cnt++;
      $display("FAIL %s_timing: got done=%0d busy_cycles=%0d overlap=%0d, want 1 %0d 0",
               name, gd, bc, ov, N);
    end
    cmp_cnt++;
    if ({s, cout, ovf} !== {es, ec, eo}) begin
      err_cnt++;
      $display("FAIL %s_result: got s=%h cout=%b ovf=%b, want s=%h cout=%b ovf=%b",
               name, s, cout, ovf, es, ec, eo);
    end
    step();
    cmp_cnt++;
    if (done !== 1'b0 || busy !== 1'b0 || s !== es) begin
      err_cnt++;
      $display("FAIL %s_after_done: got done=%b busy=%b s=%h, want 0 0 %h", name, done, busy, s, es);
    end
  endtask

  task automatic test_ignored_start();
    int bc; bit gd;
    a = 8'h01; b = 8'h01; a_ns = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    bc = 1;
    step(); bc++;
    step(); bc++;
    start = 1'b1; a = 8'hAA;
    step(); bc++;
    start = 1'b0; a = 8'h00;
    gd = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        gd = 1'b1;
        break;
      end
      step(); bc++;
    end
    cmp_cnt++;
    if (!gd || bc != N + 1) begin
      err_cnt++;
      $display("FAIL ignored_start_timing: got done=%0d edges=%0d, want 1 %0d", gd, bc, N + 1);
    end
    cmp_cnt++;
    if ({s, cout} !== {8'h02, 1'b0}) begin
      err_cnt++;
      $display("FAIL ignored_start_result: got s=%h cout=%b, want s=02 cout=0", s, cout);
    end
    step();
    cmp_cnt++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      err_cnt++;
      $display("FAIL ignored_start_no_restart: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    int bc; bit gd, ov;
    do_op(8'h05, 8'h06, 1'b1, bc, gd, ov);
    cmp_cnt++;
    if (!gd || s !== 8'h0B) begin
      err_cnt++;
      $display("FAIL b2b_first: got done=%0d s=%h, want 1 0b", gd, s);
    end
    do_op(8'h03, 8'h01, 1'b0, bc, gd, ov);
    cmp_cnt++;
    if (!gd || bc != N || ov) begin
      err_cnt++;
      $display("FAIL b2b_second_timing: got done=%0d busy_cycles=%0d overlap=%0d, want 1 %0d 0",
               gd, bc, ov, N);
    end
    cmp_cnt++;
    if ({s, cout} !== {8'h02, 1'b1}) begin
      err_cnt++;
      $display("FAIL b2b_second_result: got s=%h cout=%b, want s=02 cout=1", s, cout);
    end
    step();
  endtask

  task automatic test_reset_mid_run();
    bit saw_done;
    a = 8'h12; b = 8'h34; a_ns = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    rst_n = 1'b0;
    step();
    cmp_cnt++;
    if ({busy, done, s, cout, ovf} !== 12'h000) begin
      err_cnt++;
      $display("FAIL midrun_reset: got busy=%b done=%b s=%h cout=%b ovf=%b, want all 0",
               busy, done, s, cout, ovf);
    end
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done || busy) saw_done = 1'b1;
    end
    cmp_cnt++;
    if (saw_done) begin
      err_cnt++;
      $display("FAIL midrun_no_done: got activity=1, want 0");
    end
    test_arith("post_reset_add", 8'h01, 8'h02, 1'b1, 8'h03, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; a_ns = 1'b0;
    test_reset();
    test_arith("add",        8'h35, 8'h4A, 1'b1, 8'h7F, 1'b0, 1'b0);
    test_arith("sub_borrow", 8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0);
    test_arith("sub_nobrw",  8'h20, 8'h10, 1'b0, 8'h10, 1'b1, 1'b0);
    test_arith("ovf_pos",    8'h7F, 8'h01, 1'b1, 8'h80, 1'b0, EXP_OVF_7F);
    test_arith("wrap",       8'hFF, 8'h01, 1'b1, 8'h00, 1'b1, 1'b0);
    test_arith("sub_neg_ovf", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, EXP_OVF_7F);
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
